// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: sequencer bus (run/pc_load control, byte memory read, decode and execute handshakes, pc/busy/retired status)
interface fetch_sequencer_if #(parameter int M_WIDTH = 8);
  logic run;
  logic pc_load;
  logic [M_WIDTH-1:0] pc_load_val;
  logic [M_WIDTH-1:0] mem_addr;
  logic mem_rd_en;
  logic [M_WIDTH-1:0] mem_rdata;
  logic mem_ready;
  logic [2*M_WIDTH-1:0] ir;
  logic dec_en;
  logic dec_ready;
  logic exec_start;
  logic exec_done;
  logic branch_taken;
  logic [M_WIDTH-1:0] branch_target;
  logic halt_req;
  logic [M_WIDTH-1:0] pc;
  logic busy;
  logic [15:0] retired;
  modport master (
    input run, pc_load, pc_load_val, mem_rdata, mem_ready, dec_ready,
          exec_done, branch_taken, branch_target, halt_req,
    output mem_addr, mem_rd_en, ir, dec_en, exec_start, pc, busy, retired
  );
  modport slave (
    output run, pc_load, pc_load_val, mem_rdata, mem_ready, dec_ready,
           exec_done, branch_taken, branch_target, halt_req,
    input mem_addr, mem_rd_en, ir, dec_en, exec_start, pc, busy, retired
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: two-byte instruction fetch, decode/execute handshake, pc and retire count; ports clk, rst (async high), bus (fetch_sequencer_if.master)
module fetch_sequencer #(
  parameter int M_WIDTH = 8,
  parameter int INST_WIDTH = 2 * M_WIDTH,
  parameter logic [M_WIDTH-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  fetch_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH_HI, FETCH_LO, DECODE, EXECUTE} state_t;
  state_t state, state_n;
  logic first;
  logic [M_WIDTH-1:0] pc;
  logic [INST_WIDTH-1:0] ir;
  logic [15:0] retired;
  logic fetch, done;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      first <= 1'b0;
    end else begin
      state <= state_n;
      first <= state == DECODE && bus.dec_ready;
    end
  always_comb begin
    state_n = state;
    fetch = state == FETCH_HI || state == FETCH_LO;
    done = state == EXECUTE && bus.exec_done;
    case (state)
      IDLE:     state_n = !bus.pc_load && bus.run ? FETCH_HI : IDLE;
      FETCH_HI: state_n = bus.mem_ready ? FETCH_LO : FETCH_HI;
      FETCH_LO: state_n = bus.mem_ready ? DECODE : FETCH_LO;
      DECODE:   state_n = bus.dec_ready ? EXECUTE : DECODE;
      EXECUTE:  state_n = !bus.exec_done ? EXECUTE : !bus.halt_req && bus.run ? FETCH_HI : IDLE;
      default:  state_n = IDLE;
    endcase
    bus.mem_rd_en = fetch;
    bus.mem_addr = pc;
    bus.dec_en = state == DECODE;
    bus.exec_start = state == EXECUTE && first;
    bus.busy = state != IDLE;
    bus.pc = pc;
    bus.ir = ir;
    bus.retired = retired;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      ir <= '0;
      retired <= '0;
    end else begin
      if (state == IDLE && bus.pc_load) pc <= bus.pc_load_val;
      else if (fetch && bus.mem_ready) pc <= pc + 1'b1;
      else if (done && bus.branch_taken) pc <= bus.branch_target;
      if (state == FETCH_HI && bus.mem_ready) ir[INST_WIDTH-1:M_WIDTH] <= bus.mem_rdata;
      if (state == FETCH_LO && bus.mem_ready) ir[M_WIDTH-1:0] <= bus.mem_rdata;
      if (done) retired <= retired + 16'd1;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch_sequencer with byte memory, lagging decode and zero-wait execute models
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] mem [256];
  int waits;
  logic [7:0] wcnt;
  int total = 0;
  int bad = 0;
  int n;
  fetch_sequencer_if #(.M_WIDTH(8)) bus ();
  fetch_sequencer dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_addr];
  assign bus.mem_ready = bus.mem_rd_en && 32'(wcnt) == waits;
  assign bus.exec_done = bus.exec_start;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wcnt <= '0;
      bus.dec_ready <= 1'b0;
    end else begin
      wcnt <= bus.mem_rd_en && !bus.mem_ready ? wcnt + 8'd1 : 8'd0;
      bus.dec_ready <= bus.dec_en;
    end
  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_start(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.exec_start && k < 50);
    chk("wait_start", 32'(bus.exec_start), 32'd1);
  endtask
  function automatic logic [15:0] word(input int a);
    return {mem[a & 255], mem[(a + 1) & 255]};
  endfunction
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[8'h10] = 8'h52;
    mem[8'h11] = 8'h3C;
    mem[8'hFF] = 8'h0A;
    mem[8'h00] = 8'h40;
    rst = 1'b1;
    waits = 0;
    bus.run = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_load_val = '0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    bus.halt_req = 1'b0;
    step(2);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rd_en", 32'(bus.mem_rd_en), 0);
    chk("rst_dec_en", 32'(bus.dec_en), 0);
    chk("rst_exec_start", 32'(bus.exec_start), 0);
    chk("rst_pc", 32'(bus.pc), 0);
    chk("rst_ir", 32'(bus.ir), 0);
    chk("rst_retired", 32'(bus.retired), 0);
    rst = 1'b0;
    bus.pc_load = 1'b1;
    bus.pc_load_val = 8'h10;
    step(1);
    bus.pc_load = 1'b0;
    chk("load_pc", 32'(bus.pc), 32'h10);
    chk("load_idle", 32'(bus.busy), 0);
    bus.run = 1'b1;
    step(1);
    chk("t1_hi_rd_en", 32'(bus.mem_rd_en), 1);
    chk("t1_hi_addr", 32'(bus.mem_addr), 32'h10);
    chk("t1_hi_dec_en", 32'(bus.dec_en), 0);
    step(1);
    chk("t1_lo_addr", 32'(bus.mem_addr), 32'h11);
    chk("t1_lo_ir", 32'(bus.ir), 32'h5200);
    step(1);
    chk("t1_dec_en", 32'(bus.dec_en), 1);
    chk("t1_ir", 32'(bus.ir), 32'h523C);
    chk("t1_pc", 32'(bus.pc), 32'h12);
    step(1);
    chk("t1_dec_en2", 32'(bus.dec_en), 1);
    chk("t1_no_start", 32'(bus.exec_start), 0);
    step(1);
    chk("t1_start", 32'(bus.exec_start), 1);
    chk("t1_ret0", 32'(bus.retired), 0);
    wait_start(n);
    chk("t1_period", 32'(n), 5);
    chk("t1_ret1", 32'(bus.retired), 1);
    chk("t1_pc2", 32'(bus.pc), 32'h14);
    chk("t1_ir2", 32'(bus.ir), 32'(word(8'h12)));
    bus.run = 1'b0;
    step(1);
    chk("t1_idle", 32'(bus.busy), 0);
    chk("t1_ret2", 32'(bus.retired), 2);
    chk("t1_pc_end", 32'(bus.pc), 32'h14);
    waits = 3;
    bus.pc_load = 1'b1;
    bus.pc_load_val = 8'h20;
    step(1);
    bus.pc_load = 1'b0;
    bus.run = 1'b1;
    step(1);
    chk("t2_rd_en", 32'(bus.mem_rd_en), 1);
    chk("t2_addr_w0", 32'(bus.mem_addr), 32'h20);
    step(2);
    chk("t2_addr_w2", 32'(bus.mem_addr), 32'h20);
    chk("t2_ir_hold", 32'(bus.ir), 32'(word(8'h12)));
    step(1);
    chk("t2_addr_w3", 32'(bus.mem_addr), 32'h20);
    step(1);
    chk("t2_lo_addr", 32'(bus.mem_addr), 32'h21);
    chk("t2_ir_hi", 32'(bus.ir[15:8]), 32'(mem[8'h20]));
    step(6);
    chk("t2_start_11", 32'(bus.exec_start), 1);
    chk("t2_ir", 32'(bus.ir), 32'(word(8'h20)));
    bus.run = 1'b0;
    step(1);
    chk("t2_idle", 32'(bus.busy), 0);
    chk("t2_ret", 32'(bus.retired), 3);
    waits = 0;
    bus.pc_load = 1'b1;
    bus.pc_load_val = 8'hFF;
    bus.branch_taken = 1'b1;
    bus.branch_target = 8'h40;
    step(1);
    bus.pc_load = 1'b0;
    bus.run = 1'b1;
    step(1);
    chk("t3_addr_ff", 32'(bus.mem_addr), 32'hFF);
    step(1);
    chk("t3_addr_wrap", 32'(bus.mem_addr), 32'h00);
    chk("t3_pc_wrap", 32'(bus.pc), 32'h00);
    step(1);
    chk("t3_pc_01", 32'(bus.pc), 32'h01);
    chk("t3_ir", 32'(bus.ir), 32'h0A40);
    step(2);
    chk("t3_start", 32'(bus.exec_start), 1);
    step(1);
    chk("t3_jump_pc", 32'(bus.pc), 32'h40);
    chk("t3_jump_addr", 32'(bus.mem_addr), 32'h40);
    chk("t3_ret", 32'(bus.retired), 4);
    bus.branch_taken = 1'b0;
    wait_start(n);
    chk("t4_first", 32'(n), 4);
    wait_start(n);
    chk("t4_second", 32'(n), 5);
    step(1);
    bus.halt_req = 1'b1;
    wait_start(n);
    chk("t4_third", 32'(n), 4);
    step(1);
    chk("t4_halt_busy", 32'(bus.busy), 0);
    chk("t4_halt_rd_en", 32'(bus.mem_rd_en), 0);
    chk("t4_halt_ret", 32'(bus.retired), 7);
    chk("t4_halt_pc", 32'(bus.pc), 32'h46);
    bus.run = 1'b0;
    bus.halt_req = 1'b0;
    step(3);
    chk("t4_stay_rd_en", 32'(bus.mem_rd_en), 0);
    chk("t4_stay_busy", 32'(bus.busy), 0);
    bus.pc_load = 1'b1;
    bus.pc_load_val = 8'h50;
    step(1);
    bus.pc_load = 1'b0;
    bus.run = 1'b1;
    step(2);
    bus.run = 1'b0;
    step(1);
    chk("t5_dec_en", 32'(bus.dec_en), 1);
    step(2);
    chk("t5_start", 32'(bus.exec_start), 1);
    step(1);
    chk("t5_idle", 32'(bus.busy), 0);
    chk("t5_ret", 32'(bus.retired), 8);
    chk("t5_pc", 32'(bus.pc), 32'h52);
    step(2);
    chk("t5_stay_rd_en", 32'(bus.mem_rd_en), 0);
    bus.run = 1'b1;
    step(1);
    chk("t5_resume_rd_en", 32'(bus.mem_rd_en), 1);
    chk("t5_resume_addr", 32'(bus.mem_addr), 32'h52);
    step(2);
    chk("t6_in_decode", 32'(bus.dec_en), 1);
    rst = 1'b1;
    #1;
    chk("t6_dec_en", 32'(bus.dec_en), 0);
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_exec_start", 32'(bus.exec_start), 0);
    chk("t6_rd_en", 32'(bus.mem_rd_en), 0);
    chk("t6_pc", 32'(bus.pc), 0);
    chk("t6_ir", 32'(bus.ir), 0);
    chk("t6_retired", 32'(bus.retired), 0);
    step(1);
    rst = 1'b0;
    bus.run = 1'b0;
    step(3);
    chk("t6_idle_busy", 32'(bus.busy), 0);
    chk("t6_idle_rd_en", 32'(bus.mem_rd_en), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
